// File: rtl/top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : top                                                          |
// | Description : Prescaled 10-bit up/down counter on LEDR with pause and      |
// |               clear pushbuttons; KEY[0] is the asynchronous reset.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module top #(
    parameter int unsigned CLK_DIV = 5_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR
);

    localparam logic [25:0] c_div_last = 26'(CLK_DIV - 1);

    logic        w_rst_n;
    logic [3:1]  w_key_sync;
    logic        w_enable;
    logic        w_up;
    logic        w_clear;
    logic        w_tick;

    logic        r_key3_prev;
    logic [25:0] r_presc;
    logic [9:0]  r_count;

    assign w_rst_n = KEY[0];

    // Synchronizers reset to the released level so reset never looks like a press
    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_sync
            logic [1:0] r_meta;
            always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_meta <= 2'b11;
                end else begin
                    r_meta <= {r_meta[0], KEY[gi]};
                end
            end
            assign w_key_sync[gi] = r_meta[1];
        end
    endgenerate

    assign w_enable = w_key_sync[1];
    assign w_up     = w_key_sync[2];

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key3_prev <= 1'b1;
        end else begin
            r_key3_prev <= w_key_sync[3];
        end
    end

    // One-cycle pulse on press only; holding the button does not retrigger
    assign w_clear = r_key3_prev & ~w_key_sync[3];
    assign w_tick  = (r_presc == c_div_last);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_presc <= '0;
        end else if (w_clear || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 26'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_tick && w_enable) begin
            r_count <= w_up ? r_count + 10'd1 : r_count - 10'd1;
        end
    end

    assign LEDR = r_count;

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_top                                                       |
// | Description : Self-checking bench for top against a behavioural model.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_top;

    localparam int c_clk_div = 4;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] ledr;

    int checks = 0;
    int errors = 0;

    // Model: count value, edges since prescaler last zeroed, and KEY[3:1]
    // samples at past edges (element 0 = most recent edge).
    int         m_count;
    int         m_since;
    logic [3:1] hist[$];

    top #(.CLK_DIV(c_clk_div)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .LEDR     (ledr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0;
        m_since = 0;
        hist    = '{3'b111, 3'b111, 3'b111};
    endtask

    // One rising edge; the model sees controls two edges late and a clear
    // when the delayed KEY[3] goes from released to pressed.
    task automatic step();
        logic [3:1] s_cur;
        logic       clr;
        logic       tk;
        @(posedge clk);
        s_cur = hist[1];
        clr   = hist[2][3] && !hist[1][3];
        tk    = (m_since % c_clk_div) == (c_clk_div - 1);
        if (clr) begin
            m_count = 0;
            m_since = 0;
        end else begin
            m_since++;
            if (tk && s_cur[1])
                m_count = s_cur[2] ? (m_count + 1) % 1024 : (m_count + 1023) % 1024;
        end
        hist.push_front(key[3:1]);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic apply_reset(input logic [3:1] k);
        key = {k, 1'b0};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        key[0] = 1'b1;
    endtask

    task automatic test_reset();
        key = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ledr !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold: LEDR=%0d expected 0", ledr);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(3'b111);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (ledr !== 10'd2) begin
            errors++;
            $display("FAIL pre_async: LEDR=%0d expected 2", ledr);
        end
        key[0] = 1'b0;
        #2;
        checks++;
        if (ledr !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: LEDR=%0d expected 0 before edge", ledr);
        end
        model_reset();
    endtask

    task automatic test_count_up();
        apply_reset(3'b111);
        for (int n = 1; n <= 20; n++) begin
            for (int e = 0; e < 4; e++) begin
                step();
                checks++;
                if (ledr !== 10'(m_count)) begin
                    errors++;
                    $display("FAIL count_up_model: LEDR=%0d expected %0d", ledr, m_count);
                end
            end
            checks++;
            if (ledr !== 10'(n)) begin
                errors++;
                $display("FAIL count_up_n: LEDR=%0d expected %0d", ledr, n);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset(3'b111);
        for (int e = 1; e <= 4100; e++) begin
            step();
            checks++;
            if (ledr !== 10'(m_count)) begin
                errors++;
                $display("FAIL wrap_model: edge %0d LEDR=%0d expected %0d", e, ledr, m_count);
            end
            if (e == 4092 || e == 4096 || e == 4100) begin
                checks++;
                if (ledr !== ((e == 4092) ? 10'd1023 : (e == 4096) ? 10'd0 : 10'd1)) begin
                    errors++;
                    $display("FAIL wrap_point: edge %0d LEDR=%0d", e, ledr);
                end
            end
        end
    endtask

    task automatic test_pause();
        apply_reset(3'b111);
        repeat (20) step();
        checks++;
        if (ledr !== 10'd5) begin
            errors++;
            $display("FAIL pause_start: LEDR=%0d expected 5", ledr);
        end
        key[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (ledr !== 10'd5) begin
                errors++;
                $display("FAIL pause_hold: LEDR=%0d expected 5", ledr);
            end
        end
        key[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (ledr !== 10'(m_count)) begin
                errors++;
                $display("FAIL pause_resume: LEDR=%0d expected %0d", ledr, m_count);
            end
        end
        checks++;
        if (ledr !== 10'd8) begin
            errors++;
            $display("FAIL pause_end: LEDR=%0d expected 8", ledr);
        end
    endtask

    task automatic test_down();
        apply_reset(3'b101);
        for (int t = 1; t <= 3; t++) begin
            repeat (4) step();
            checks++;
            if (ledr !== 10'(1024 - t)) begin
                errors++;
                $display("FAIL down_tick: LEDR=%0d expected %0d", ledr, 1024 - t);
            end
        end
    endtask

    task automatic test_clear();
        apply_reset(3'b111);
        repeat (28) step();
        checks++;
        if (ledr !== 10'd7) begin
            errors++;
            $display("FAIL clear_start: LEDR=%0d expected 7", ledr);
        end
        key[3] = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (e <= 7) begin
                checks++;
                if (ledr !== ((e <= 2) ? 10'd7 : (e <= 6) ? 10'd0 : 10'd1)) begin
                    errors++;
                    $display("FAIL clear_seq: edge %0d after press LEDR=%0d", e, ledr);
                end
            end
            checks++;
            if (ledr !== 10'(m_count)) begin
                errors++;
                $display("FAIL clear_hold: LEDR=%0d expected %0d", ledr, m_count);
            end
        end
        key[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (ledr !== 10'(m_count)) begin
                errors++;
                $display("FAIL clear_release: LEDR=%0d expected %0d", ledr, m_count);
            end
        end
    endtask

    task automatic test_random();
        apply_reset(3'b111);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) key[3:1] = 3'($urandom);
            step();
            checks++;
            if (ledr !== 10'(m_count)) begin
                errors++;
                $display("FAIL random: cycle %0d KEY=%b LEDR=%0d expected %0d",
                         i, key, ledr, m_count);
            end
        end
    endtask

    initial begin
        key = 4'b0000;
        model_reset();
        test_reset();
        test_async_reset();
        test_count_up();
        test_wrap();
        test_pause();
        test_down();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
